obj_line_scanner: RTL and testbench

Per-scanline object scanner for the M107 sprite path: it reads the 512-entry object RAM that the GA21 copy engine fills, selects the objects that intersect the requested line, and queues one draw descriptor per hit for the line renderer. It sits between the object RAM read port and the sprite line-buffer renderer, and is paced by the system clock enable `ce`. Object RAM is treated as read-only here; the copy engine owns it while `obj_busy` is high.

---
 rtl/obj_line_scanner.sv | 235 +++++++++++++++++++++++
 tb/tb_obj_line_scanner.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_line_scanner.sv
// Scanline object scanner: walks object RAM, queues a draw descriptor per object hitting the line.
// Latency: 3 ce per missed object, 7 ce per hit; descriptor visible one ce after its PUSH.
// Backpressure: full descriptor FIFO holds the scan in PUSH; obj_busy freezes the walk.

module obj_line_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = count[AW];
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (ce) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        if (do_push && !do_pop)      count <= count + (AW+1)'(1);
        else if (!do_push && do_pop) count <= count - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ce && do_push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

module obj_line_scanner #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        line_start,
  input  logic [8:0]  line,
  input  logic        obj_busy,
  output logic [10:0] obj_addr,
  input  logic [15:0] obj_din,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic [15:0] desc_code,
  output logic [3:0]  desc_row,
  output logic [9:0]  desc_x,
  output logic [6:0]  desc_color,
  output logic        desc_prio,
  output logic        desc_flipx,
  output logic        scan_active,
  output logic        scan_done,
  output logic        overrun
);
  typedef struct packed {
    logic [15:0] code;
    logic [3:0]  row;
    logic [9:0]  x;
    logic [6:0]  color;
    logic        prio;
    logic        flipx;
  } desc_t;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_Y    = 3'd1;
  localparam logic [2:0] S_CHK_Y   = 3'd2;
  localparam logic [2:0] S_RD_CODE = 3'd3;
  localparam logic [2:0] S_RD_ATTR = 3'd4;
  localparam logic [2:0] S_RD_X    = 3'd5;
  localparam logic [2:0] S_PUSH    = 3'd6;
  localparam logic [2:0] S_NEXT    = 3'd7;

  logic [2:0]  state;
  logic [8:0]  idx;
  logic [8:0]  line_q;
  logic [6:0]  row_q;
  logic [1:0]  h_q;
  logic [15:0] code_q;
  logic [9:0]  attr_q;

  logic        step;
  logic        completing;
  logic        restart_flush;
  logic        fifo_push;
  logic        fifo_empty;
  logic        fifo_full;
  logic [8:0]  row_chk;
  logic        hit;
  logic [6:0]  hmask;
  logic [6:0]  r_flip;
  desc_t       new_desc;
  desc_t       head;
  desc_t       shown;

  assign step          = ce && !obj_busy;
  assign completing    = step && (state == S_NEXT) && (idx == 9'd511);
  assign restart_flush = line_start && scan_active && !completing;
  assign fifo_push     = step && (state == S_PUSH) && !line_start;

  assign row_chk = line_q - obj_din[8:0];
  assign hit     = row_chk < (9'd16 << obj_din[10:9]);

  // Rows are kept in-tile (< 128), so the flip works on 7 bits with hpx-1 as a mask.
  assign hmask  = {h_q == 2'd3, h_q[1], h_q != 2'd0, 4'hF};
  assign r_flip = attr_q[9] ? (hmask - row_q) : row_q;

  always_comb begin
    new_desc       = '0;
    new_desc.code  = code_q + {13'd0, r_flip[6:4]};
    new_desc.row   = r_flip[3:0];
    new_desc.x     = obj_din[9:0];
    new_desc.color = attr_q[6:0];
    new_desc.prio  = attr_q[7];
    new_desc.flipx = attr_q[8];
  end

  obj_line_fifo #(.W($bits(desc_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .flush    (restart_flush),
    .push     (fifo_push),
    .push_dat (new_desc),
    .pop      (desc_ready && desc_valid),
    .head_dat (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign desc_valid = !fifo_empty;
  assign shown      = desc_valid ? head : '0;
  assign desc_code  = shown.code;
  assign desc_row   = shown.row;
  assign desc_x     = shown.x;
  assign desc_color = shown.color;
  assign desc_prio  = shown.prio;
  assign desc_flipx = shown.flipx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      line_q      <= '0;
      row_q       <= '0;
      h_q         <= '0;
      code_q      <= '0;
      attr_q      <= '0;
      obj_addr    <= '0;
      scan_active <= 1'b0;
      scan_done   <= 1'b0;
      overrun     <= 1'b0;
    end else if (ce) begin
      scan_done <= completing;
      overrun   <= restart_flush;
      if (line_start) begin
        line_q      <= line;
        idx         <= '0;
        state       <= S_RD_Y;
        scan_active <= 1'b1;
      end else if (!obj_busy) begin
        // obj_addr only moves on a taken step, so a busy stall re-reads the same word.
        case (state)
          S_RD_Y: begin
            obj_addr <= {idx, 2'd0};
            state    <= S_CHK_Y;
          end
          S_CHK_Y: begin
            if (hit) begin
              row_q <= row_chk[6:0];
              h_q   <= obj_din[10:9];
              state <= S_RD_CODE;
            end else begin
              state <= S_NEXT;
            end
          end
          S_RD_CODE: begin
            obj_addr <= {idx, 2'd1};
            state    <= S_RD_ATTR;
          end
          S_RD_ATTR: begin
            code_q   <= obj_din;
            obj_addr <= {idx, 2'd2};
            state    <= S_RD_X;
          end
          S_RD_X: begin
            attr_q   <= obj_din[9:0];
            obj_addr <= {idx, 2'd3};
            state    <= S_PUSH;
          end
          S_PUSH: begin
            if (!fifo_full) state <= S_NEXT;
          end
          S_NEXT: begin
            if (idx == 9'd511) begin
              idx         <= '0;
              state       <= S_IDLE;
              scan_active <= 1'b0;
            end else begin
              idx   <= idx + 9'd1;
              state <= S_RD_Y;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_obj_line_scanner.sv
// Directed + randomized bench for obj_line_scanner against a per-object arithmetic reference model.
module tb_obj_line_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        line_start = 1'b0;
  logic [8:0]  line = '0;
  logic        obj_busy = 1'b0;
  logic        desc_ready = 1'b0;
  logic [10:0] obj_addr;
  logic [15:0] obj_din;
  logic        desc_valid;
  logic [15:0] desc_code;
  logic [3:0]  desc_row;
  logic [9:0]  desc_x;
  logic [6:0]  desc_color;
  logic        desc_prio;
  logic        desc_flipx;
  logic        scan_active;
  logic        scan_done;
  logic        overrun;

  logic [15:0] mem [2048];
  logic [15:0] garbage = 16'hA5A5;
  int          n_assert = 0;
  int          n_fail = 0;
  int          rdy_mode = 0;
  int          exp_len;
  int          len;
  logic [38:0] got_q[$];
  logic [38:0] exp_q[$];

  always #5 clk = ~clk;

  // Object RAM: data for the registered address; unusable while the copy engine owns it.
  assign obj_din = obj_busy ? garbage : mem[obj_addr];

  obj_line_scanner #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .ce(ce), .line_start(line_start), .line(line),
    .obj_busy(obj_busy), .obj_addr(obj_addr), .obj_din(obj_din),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_code(desc_code),
    .desc_row(desc_row), .desc_x(desc_x), .desc_color(desc_color),
    .desc_prio(desc_prio), .desc_flipx(desc_flipx), .scan_active(scan_active),
    .scan_done(scan_done), .overrun(overrun)
  );

  function automatic logic [38:0] cur_desc();
    return {desc_code, desc_row, desc_x, desc_color, desc_prio, desc_flipx};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk all 512 objects, keep hits in index order; return no-stall scan length.
  function automatic int model(input logic [8:0] ln);
    int hits = 0;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      logic [15:0] w0 = mem[4*i];
      logic [15:0] w1 = mem[4*i+1];
      logic [15:0] w2 = mem[4*i+2];
      logic [15:0] w3 = mem[4*i+3];
      int hpx = 16 << w0[10:9];
      int row = (int'(ln) - int'(w0[8:0]) + 512) % 512;
      if (row < hpx) begin
        int r = w2[9] ? (hpx - 1 - row) : row;
        logic [15:0] code = 16'(int'(w1) + r / 16);
        hits++;
        exp_q.push_back({code, 4'(r % 16), w3[9:0], w2[6:0], w2[7], w2[8]});
      end
    end
    return 1536 + 4 * hits;
  endfunction

  // One ce, with an occasional idle clock in front to exercise ce gating.
  task automatic ce_tick();
    if ($urandom_range(0, 3) == 0) begin
      ce = 1'b0;
      @(posedge clk);
      #1;
    end
    case (rdy_mode)
      0:       desc_ready = 1'b1;
      1:       desc_ready = 1'($urandom_range(0, 1));
      default: desc_ready = 1'b0;
    endcase
    garbage = 16'($urandom);
    ce = 1'b1;
    #1;
    if (desc_valid && desc_ready) got_q.push_back(cur_desc());
    @(posedge clk);
    #1;
    ce = 1'b0;
  endtask

  task automatic set_obj(input int i, input logic [8:0] y, input logic [1:0] h,
                         input logic [15:0] code, input logic [15:0] attr);
    mem[4*i]   = {5'd0, h, y};
    mem[4*i+1] = code;
    mem[4*i+2] = attr;
    mem[4*i+3] = 16'($urandom_range(0, 1023));
  endtask

  task automatic fill_miss();
    for (int i = 0; i < 512; i++)
      set_obj(i, 9'h1F0, 2'd0, 16'($urandom), 16'($urandom_range(0, 1023)));
  endtask

  task automatic fill_stall_set();
    fill_miss();
    for (int k = 0; k < 20; k++)
      set_obj(3*k + 1, 9'd100, 2'd0, 16'($urandom), 16'($urandom_range(0, 1023)));
  endtask

  task automatic start(input logic [8:0] ln);
    line = ln;
    line_start = 1'b1;
    ce_tick();
    line_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int busy_at, input int busy_len, output int n);
    n = 0;
    do begin
      obj_busy = (n + 1 >= busy_at) && (n + 1 < busy_at + busy_len);
      ce_tick();
      n++;
    end while (!scan_done && n < 8000);
    obj_busy = 1'b0;
    check({tag, " scan_done"}, 64'(scan_done), 64'(1));
    check({tag, " active falls"}, 64'(scan_active), 64'(0));
  endtask

  task automatic drain(input string tag);
    rdy_mode = 0;
    for (int n = 0; n < 64 && desc_valid; n++) ce_tick();
    check({tag, " drained"}, 64'(desc_valid), 64'(0));
  endtask

  task automatic compare(input string tag);
    check({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s desc%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic scan(input string tag, input logic [8:0] ln, input int mode,
                      input int busy_at, input int busy_len, input bit chk_len);
    int n;
    got_q.delete();
    exp_len = model(ln);
    rdy_mode = mode;
    start(ln);
    check({tag, " active rises"}, 64'(scan_active), 64'(1));
    check({tag, " no overrun"}, 64'(overrun), 64'(0));
    wait_done(tag, busy_at, busy_len, n);
    if (chk_len) check({tag, " length"}, 64'(n), 64'(exp_len + busy_len));
    drain(tag);
    compare(tag);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst obj_addr", 64'(obj_addr), 64'(0));
    check("rst desc_valid", 64'(desc_valid), 64'(0));
    check("rst desc", 64'(cur_desc()), 64'(0));
    check("rst scan_active", 64'(scan_active), 64'(0));
    check("rst scan_done", 64'(scan_done), 64'(0));
    check("rst overrun", 64'(overrun), 64'(0));
    reset = 1'b0;

    // Single hit among misses
    fill_miss();
    set_obj(5, 9'd10, 2'd0, 16'h1234, 16'($urandom_range(0, 511)));
    scan("single", 9'd12, 0, 0, 0, 1'b1);
    if (got_q.size() > 0) begin
      check("single code", 64'(got_q[0][38:23]), 64'(16'h1234));
      check("single row", 64'(got_q[0][22:19]), 64'(2));
    end

    // Same scan with obj_busy held over the hit's RD_ATTR
    scan("busy", 9'd12, 0, 19, 7, 1'b1);

    // Wrap-around hit with flipy on a 32-pixel object
    fill_miss();
    set_obj(7, 9'h1F8, 2'd1, 16'h0100, 16'h0200 | 16'($urandom_range(0, 511)));
    scan("wrap", 9'd4, 0, 0, 0, 1'b1);
    if (got_q.size() > 0) begin
      check("wrap code", 64'(got_q[0][38:23]), 64'(16'h0101));
      check("wrap row", 64'(got_q[0][22:19]), 64'(3));
    end

    // Random object tables, random and full-rate ready
    for (int t = 0; t < 2; t++) begin
      logic [8:0] ln = 9'($urandom);
      for (int i = 0; i < 512; i++) begin
        logic [1:0] h = 2'($urandom);
        logic [8:0] y = ln - 9'($urandom_range(0, 400));
        mem[4*i]   = {5'd0, h, y};
        mem[4*i+1] = 16'($urandom);
        mem[4*i+2] = 16'($urandom);
        mem[4*i+3] = 16'($urandom);
      end
      scan($sformatf("rand%0d", t), ln, (t == 0) ? 1 : 0, 0, 0, t == 1);
    end

    // 20 hits with the renderer stalled: FIFO fills and the scan parks in PUSH
    fill_stall_set();
    got_q.delete();
    exp_len = model(9'd105);
    rdy_mode = 2;
    start(9'd105);
    repeat (400) ce_tick();
    check("stall addr", 64'(obj_addr), 64'({9'd49, 2'd3}));
    check("stall no done", 64'(scan_done), 64'(0));
    check("stall valid", 64'(desc_valid), 64'(1));
    rdy_mode = 0;
    wait_done("stall", 0, 0, len);
    drain("stall");
    compare("stall");

    // Second line_start mid-scan: overrun, flush, restart on the new line
    got_q.delete();
    rdy_mode = 2;
    start(9'd105);
    repeat (499) ce_tick();
    line = 9'h1F5;
    line_start = 1'b1;
    ce_tick();
    line_start = 1'b0;
    check("ovr pulse", 64'(overrun), 64'(1));
    check("ovr flushed", 64'(desc_valid), 64'(0));
    check("ovr active", 64'(scan_active), 64'(1));
    exp_len = model(9'h1F5);
    rdy_mode = 0;
    got_q.delete();
    ce_tick();
    check("ovr pulse ends", 64'(overrun), 64'(0));
    wait_done("ovr", 0, 0, len);
    check("ovr length", 64'(len + 1), 64'(exp_len));
    drain("ovr");
    compare("ovr");

    // line_start on the final NEXT: restart wins, scan_done pulses, no overrun
    fill_miss();
    got_q.delete();
    rdy_mode = 0;
    start(9'd20);
    repeat (1535) ce_tick();
    line = 9'd30;
    line_start = 1'b1;
    ce_tick();
    line_start = 1'b0;
    check("coinc done", 64'(scan_done), 64'(1));
    check("coinc no overrun", 64'(overrun), 64'(0));
    check("coinc active", 64'(scan_active), 64'(1));
    exp_len = model(9'd30);
    wait_done("coinc", 0, 0, len);
    check("coinc length", 64'(len), 64'(exp_len));

    // Asynchronous reset while parked in PUSH with a full FIFO
    fill_stall_set();
    rdy_mode = 2;
    start(9'd105);
    repeat (300) ce_tick();
    #2 reset = 1'b1;
    #1;
    check("arst desc_valid", 64'(desc_valid), 64'(0));
    check("arst desc", 64'(cur_desc()), 64'(0));
    check("arst obj_addr", 64'(obj_addr), 64'(0));
    check("arst active", 64'(scan_active), 64'(0));
    check("arst done", 64'(scan_done), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    fill_miss();
    set_obj(5, 9'd10, 2'd0, 16'h1234, 16'($urandom_range(0, 511)));
    scan("post_rst", 9'd12, 0, 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
